// File: rtl/pkt_dmux_n.sv
// pkt_dmux_n: classifies each packet on the 134-bit metadata/packet bus from
// its first two beats and replicates it onto a masked subset of N_OUT channels.
// Beats pass through a two-stage buffer (b1 -> b0) and a registered output
// stage, so a beat sampled on edge k is presented on out_data after edge k+2.
module pkt_dmux_n #(
  parameter int          DW        = 134,
  parameter int          N_OUT     = 4,
  parameter logic [15:0] PTP_ETYPE = 16'h88F7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pktin_data_wr,
  input  logic [DW-1:0]    pktin_data,
  input  logic             pktin_data_valid,
  input  logic             pktin_data_valid_wr,
  output logic             pktin_ready,
  output logic [N_OUT-1:0] out_data_wr,
  output logic [DW-1:0]    out_data,
  output logic             out_data_valid,
  output logic [N_OUT-1:0] out_data_valid_wr,
  input  logic [N_OUT-1:0] out_alf,
  input  logic [47:0]      device_mac,
  input  logic [1:0]       device_role,
  input  logic [N_OUT-1:0] cfg_local_mask,
  input  logic [N_OUT-1:0] cfg_fwd_mask,
  input  logic [N_OUT-1:0] cfg_nonptp_mask,
  output logic [31:0]      drop_cnt,
  output logic [15:0]      err_cnt
);

  localparam logic [1:0] TAG_HEAD = 2'b01;
  localparam logic [1:0] TAG_TAIL = 2'b10;

  // Input-side packet tracking: HDR waits for the classifying beat,
  // FWD/DROP accept the body until the tail has entered.
  typedef enum logic [1:0] {S_IDLE, S_HDR, S_FWD, S_DROP} state_t;

  state_t r_state, w_state_next;

  logic [DW-1:0]    r_b0_data, r_b1_data;
  logic             r_b0_v, r_b1_v;
  logic             r_b0_tail, r_b1_tail;
  logic             r_b0_good, r_b1_good;
  logic [N_OUT-1:0] r_b0_mask, r_b1_mask;
  logic [N_OUT-1:0] r_sel_mask;

  logic [N_OUT-1:0] r_out_wr, r_out_vwr;
  logic [DW-1:0]    r_out_data;
  logic             r_out_valid;
  logic [31:0]      r_drop_cnt;
  logic [15:0]      r_err_cnt;

  logic [1:0]       w_tag_in;
  logic [47:0]      w_dmac;
  logic [15:0]      w_etype, w_ptype;
  logic             w_is_local, w_is_bcast;
  logic [N_OUT-1:0] w_cls_mask;
  logic             w_take, w_abort, w_classify;
  logic             w_emit;
  logic [N_OUT-1:0] w_ch_wr, w_ch_vwr;
  logic             w_unused_role;

  assign pktin_ready   = ~|out_alf;
  assign w_tag_in      = pktin_data[DW-1:DW-2];
  assign w_dmac        = pktin_data[127:80];
  assign w_etype       = pktin_data[31:16];
  assign w_ptype       = pktin_data[15:0];
  assign w_is_local    = (w_dmac == device_mac);
  assign w_is_bcast    = (w_dmac == 48'hFFFF_FFFF_FFFF);
  assign w_unused_role = device_role[0];

  // Class mask derived from the beat that follows the metadata head.
  always_comb begin
    w_cls_mask = '0;
    if (w_etype != PTP_ETYPE) begin
      w_cls_mask = cfg_nonptp_mask;
    end else if (device_role[1]) begin
      if (w_is_local && (w_ptype == 16'h0301 || w_ptype == 16'h0401))
        w_cls_mask = cfg_local_mask;
      else if (w_is_bcast)
        w_cls_mask = cfg_local_mask | cfg_fwd_mask;
      else
        w_cls_mask = cfg_fwd_mask;
    end else if (w_is_local || w_is_bcast) begin
      w_cls_mask = cfg_local_mask;
    end
  end

  // Next-state and beat acceptance; a missing beat before the tail aborts.
  always_comb begin
    w_state_next = r_state;
    w_take       = 1'b0;
    w_abort      = 1'b0;
    w_classify   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (pktin_data_wr && w_tag_in == TAG_HEAD && pktin_ready) begin
          w_take       = 1'b1;
          w_state_next = S_HDR;
        end
      end
      S_HDR: begin
        if (pktin_data_wr) begin
          w_take     = 1'b1;
          w_classify = 1'b1;
          if (w_tag_in == TAG_TAIL)
            w_state_next = S_IDLE;
          else if (w_cls_mask == '0)
            w_state_next = S_DROP;
          else
            w_state_next = S_FWD;
        end else begin
          w_abort      = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: begin
        if (pktin_data_wr) begin
          w_take = 1'b1;
          if (w_tag_in == TAG_TAIL)
            w_state_next = S_IDLE;
        end else begin
          w_abort      = 1'b1;
          w_state_next = S_IDLE;
        end
      end
    endcase
  end

  // On abort only a completed previous packet's tail may still leave b0;
  // beats of the aborted packet that are still buffered are discarded.
  assign w_emit = r_b0_v & (~w_abort | r_b0_tail);

  genvar gi;
  generate
    for (gi = 0; gi < N_OUT; gi++) begin : g_ch
      assign w_ch_wr[gi]  = w_emit & r_b0_mask[gi];
      assign w_ch_vwr[gi] = w_emit & r_b0_tail & r_b0_mask[gi];
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Beat buffer: shifts every cycle; the head picks up its mask as it
  // moves into b0, on the same edge that classifies the packet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_b1_v    <= 1'b0;
      r_b1_data <= '0;
      r_b1_tail <= 1'b0;
      r_b1_good <= 1'b0;
      r_b1_mask <= '0;
      r_b0_v    <= 1'b0;
      r_b0_data <= '0;
      r_b0_tail <= 1'b0;
      r_b0_good <= 1'b0;
      r_b0_mask <= '0;
    end else begin
      r_b1_v    <= w_take;
      r_b1_data <= w_take ? pktin_data : '0;
      r_b1_tail <= w_take && (w_tag_in == TAG_TAIL);
      r_b1_good <= w_take && (w_tag_in == TAG_TAIL) && pktin_data_valid_wr && pktin_data_valid;
      r_b1_mask <= w_classify ? w_cls_mask : r_sel_mask;
      if (w_abort) begin
        r_b0_v    <= 1'b0;
        r_b0_data <= '0;
        r_b0_tail <= 1'b0;
        r_b0_good <= 1'b0;
        r_b0_mask <= '0;
      end else begin
        r_b0_v    <= r_b1_v;
        r_b0_data <= r_b1_data;
        r_b0_tail <= r_b1_tail;
        r_b0_good <= r_b1_good;
        r_b0_mask <= w_classify ? w_cls_mask : r_b1_mask;
      end
    end
  end

  // Selection mask is held from classification until the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_sel_mask <= '0;
    else if (w_classify) r_sel_mask <= w_cls_mask;
  end

  // Registered outputs; data bus forced to zero whenever no strobe is up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_wr    <= '0;
      r_out_vwr   <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_wr    <= w_ch_wr;
      r_out_vwr   <= w_ch_vwr;
      r_out_data  <= (|w_ch_wr) ? r_b0_data : '0;
      r_out_valid <= (|w_ch_vwr) ? r_b0_good : 1'b0;
    end
  end

  // Saturating drop (empty mask) and abort counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt <= '0;
      r_err_cnt  <= '0;
    end else begin
      if (w_classify && w_cls_mask == '0 && r_drop_cnt != 32'hFFFF_FFFF)
        r_drop_cnt <= r_drop_cnt + 32'd1;
      if (w_abort && r_err_cnt != 16'hFFFF)
        r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign out_data_wr       = r_out_wr;
  assign out_data_valid_wr = r_out_vwr;
  assign out_data          = r_out_data;
  assign out_data_valid    = r_out_valid;
  assign drop_cnt          = r_drop_cnt;
  assign err_cnt           = r_err_cnt;

endmodule
